// File: rtl/botrom_writer.sv
// Writer for the bottom decode ROM image: streams bytes into ROM addresses 0..DEPTH-1 in order.
// Optional trailing checksum byte is enabled by defining BOTROM_CKSUM_EN.
module botrom_writer #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

`ifdef BOTROM_CKSUM_EN
  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
`endif

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;
  logic                    in_ready_q, in_ready_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    accept;
  logic                    active_d;
`ifdef BOTROM_CKSUM_EN
  logic [DATA_WIDTH-1:0]   sum_q, sum_d;
  logic [DATA_WIDTH-1:0]   cksum_total;
  logic                    err_q, err_d;
`endif

  // in_ready_q is high exactly in LOAD/CHECK, so it doubles as the accept qualifier.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
`ifdef BOTROM_CKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
    cksum_total = sum_q + in_data;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start && !abort) begin
          state_d = StLoad;
          count_d = '0;
          done_d  = 1'b0;
`ifdef BOTROM_CKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      StLoad: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q;
          wr_data_d = in_data;
`ifdef BOTROM_CKSUM_EN
          sum_d     = cksum_total;
`endif
          if (count_q == LastAddr) begin
`ifdef BOTROM_CKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
            done_d  = 1'b1;
`endif
          end else begin
            count_d = count_q + ADDR_WIDTH'(1);
          end
        end
        // The byte accepted in an abort cycle still lands as one trailing write.
        if (abort) begin
          state_d = StIdle;
          done_d  = 1'b0;
`ifdef BOTROM_CKSUM_EN
          err_d   = 1'b0;
`endif
        end
      end
`ifdef BOTROM_CKSUM_EN
      StCheck: begin
        if (accept) begin
          state_d = StDone;
          done_d  = 1'b1;
          err_d   = (cksum_total != '0);
        end
        if (abort) begin
          state_d = StIdle;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

`ifdef BOTROM_CKSUM_EN
    active_d = (state_d == StLoad) || (state_d == StCheck);
`else
    active_d = (state_d == StLoad);
`endif
    in_ready_d = active_d;
    busy_d     = active_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BOTROM_CKSUM_EN
      sum_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef BOTROM_CKSUM_EN
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef BOTROM_CKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
